// File: rtl/apb_regfile_v2_pkg.sv
// apb_regfile_v2_pkg: FSM states, register indices and access types for apb_regfile_v2
package apb_regfile_v2_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  typedef enum logic [2:0] {ACC_RW, ACC_RO, ACC_W1C, ACC_W1S, ACC_WO, ACC_NONE} acc_t;
  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_STATUS   = 3'd1;
  localparam logic [2:0] IDX_INT_FLAG = 3'd2;
  localparam logic [2:0] IDX_INT_EN   = 3'd3;
  localparam logic [2:0] IDX_CMD      = 3'd4;
  localparam logic [2:0] IDX_WO       = 3'd5;
  localparam logic [2:0] IDX_LOCK_CFG = 3'd6;
  function automatic acc_t acc_type(input logic [2:0] idx);
    return idx == IDX_STATUS   ? ACC_RO  :
           idx == IDX_INT_FLAG ? ACC_W1C :
           idx == IDX_CMD      ? ACC_W1S :
           idx == IDX_WO       ? ACC_WO  :
           idx == 3'd7         ? ACC_NONE : ACC_RW;
  endfunction
endpackage

// File: rtl/apb_slave_fsm.sv
// apb_slave_fsm: APB slave IDLE/SETUP/ACCESS sequencer with wait-state counter, pready and write commit strobe
module apb_slave_fsm
  import apb_regfile_v2_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  output logic pready,
  output logic commit
);
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = !psel ? IDLE :
               state == IDLE  ? (penable ? IDLE : SETUP) :
               state == SETUP ? ACCESS :
               pready ? IDLE : ACCESS;
    cnt_nx = !psel ? '0 :
             state == SETUP ? 3'(WAIT_STATES) :
             (state == ACCESS && cnt != 3'd0) ? cnt - 3'd1 : cnt;
  end
  always_comb begin
    pready = state == ACCESS && cnt == 3'd0;
    commit = psel && penable && pwrite && pready;
  end
endmodule

// File: rtl/apb_regfile_v2.sv
// apb_regfile_v2: APB register file (CTRL/STATUS/INT_FLAG/INT_EN/CMD/WO/LOCK_CFG); byte strobes with APB_REGFILE_PSTRB_EN
module apb_regfile_v2
  import apb_regfile_v2_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] CTRL_RST = '0,
  parameter logic [DATA_W-1:0] LOCK_RST = DATA_W'(32'h12345678)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
`ifdef APB_REGFILE_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [DATA_W-1:0] hw_status,
  input  logic [DATA_W-1:0] hw_event,
  input  logic [DATA_W-1:0] cmd_clr,
  output logic [DATA_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] int_en_o,
  output logic [DATA_W-1:0] cmd_o,
  output logic [DATA_W-1:0] lock_cfg_o,
  output logic [DATA_W-1:0] wo_data_o,
  output logic              wo_pulse,
  output logic              irq,
  output logic              locked
);
  localparam int SH = $clog2(DATA_W/8);
  logic [ADDR_W-1:0] idx_full;
  logic [2:0] idx;
  acc_t acc;
  logic commit, err, wr;
  logic [DATA_W-1:0] mask, bits, rd, int_flag, ctrl_nx;
  apb_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pready(pready), .commit(commit)
  );
`ifdef APB_REGFILE_PSTRB_EN
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W/8; i++) mask[i*8 +: 8] = {8{pstrb[i]}};
  end
`else
  assign mask = '1;
`endif
  always_comb begin
    idx_full = paddr >> SH;
    idx = idx_full[2:0];
    acc = acc_type(idx);
    err = paddr[SH-1:0] != '0 || |idx_full[ADDR_W-1:3] || acc == ACC_NONE ||
          (pwrite && acc == ACC_RO) || (!pwrite && acc == ACC_WO) ||
          (pwrite && locked && (idx == IDX_CTRL || idx == IDX_LOCK_CFG));
    wr = commit && !err;
    bits = pwdata & mask;
    ctrl_nx = (ctrl_o & ~mask) | bits;
    rd = idx == IDX_CTRL     ? ctrl_o :
         idx == IDX_STATUS   ? hw_status :
         idx == IDX_INT_FLAG ? int_flag :
         idx == IDX_INT_EN   ? int_en_o :
         idx == IDX_CMD      ? cmd_o :
         idx == IDX_LOCK_CFG ? lock_cfg_o : '0;
    prdata = (pready && !pwrite && !err) ? rd : '0;
    pslverr = pready && err;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ctrl_o <= CTRL_RST;
      lock_cfg_o <= LOCK_RST;
      int_flag <= '0;
      int_en_o <= '0;
      cmd_o <= '0;
      wo_data_o <= '0;
      wo_pulse <= 1'b0;
      irq <= 1'b0;
      locked <= 1'b0;
    end else begin
      if (wr && idx == IDX_CTRL) ctrl_o <= ctrl_nx;
      if (wr && idx == IDX_INT_EN) int_en_o <= (int_en_o & ~mask) | bits;
      if (wr && idx == IDX_LOCK_CFG) lock_cfg_o <= (lock_cfg_o & ~mask) | bits;
      if (wr && idx == IDX_WO) wo_data_o <= (wo_data_o & ~mask) | bits;
      int_flag <= (int_flag & ~((wr && idx == IDX_INT_FLAG) ? bits : '0)) | hw_event;
      cmd_o <= (cmd_o & ~cmd_clr) | ((wr && idx == IDX_CMD) ? bits : '0);
      wo_pulse <= wr && idx == IDX_WO;
      irq <= |(int_flag & int_en_o);
      locked <= locked || (wr && idx == IDX_CTRL && ctrl_nx[DATA_W-1]);
    end
endmodule

// File: doc/apb_regfile_v2.md
APB_REGFILE_V2 -- requirements
Module: apb_regfile_v2

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning register/bus width; legal values are 16, 32 and 64.
REQ-003 SHALL have parameter WAIT_STATES, default 0, meaning pready-low cycles per access; legal range is 0..7.
REQ-004 SHALL have parameter CTRL_RST, default 0, meaning CTRL reset value.
REQ-005 SHALL have parameter LOCK_RST, default 32'h12345678 zero-extended or truncated to DATA_W, meaning LOCK_CFG reset value.
REQ-006 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- paddr  in  ADDR_W  APB address.
- psel, penable, pwrite  in  1 each  APB controls.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  byte strobes; present only when APB_REGFILE_PSTRB_EN is defined.
- prdata  out  DATA_W  read data.
- pready, pslverr  out  1 each  APB response.
- hw_status  in  DATA_W  STATUS source.
- hw_event  in  DATA_W  INT_FLAG set pulses.
- cmd_clr  in  DATA_W  CMD per-bit hardware clear.
- ctrl_o, int_en_o, cmd_o, lock_cfg_o, wo_data_o  out  DATA_W each  register values.
- wo_pulse  out  1  one-cycle WO write strobe.
- irq  out  1  interrupt.
- locked  out  1  lock state.

Function
REQ-007 SHALL decode register index = paddr/(DATA_W/8): 0 CTRL RW, 1 STATUS RO, 2 INT_FLAG W1C, 3 INT_EN RW, 4 CMD W1S, 5 WO write-only, 6 LOCK_CFG RW.
- Any other index, or an address that is not stride-aligned, is unmapped.
REQ-008 SHALL run a slave FSM with states IDLE, SETUP and ACCESS.
- IDLE to SETUP on psel&!penable.
- SETUP to ACCESS unconditionally.
- ACCESS to IDLE when pready=1.
REQ-009 SHALL load a wait counter with WAIT_STATES in SETUP and decrement it each ACCESS cycle while it is nonzero; pready SHALL equal (state==ACCESS && counter==0).
REQ-010 SHALL commit a write only on the single clk edge where psel&penable&pwrite&pready=1; the register updates on the next cycle.
REQ-011 SHALL drive prdata with the addressed value only while state==ACCESS, pwrite=0 and pready=1; prdata SHALL be 0 at all other times.
- WO, unmapped addresses and error responses read 0.
REQ-012 SHALL assert pslverr, only together with pready, for:
- any unmapped access;
- a write to STATUS;
- a read of WO;
- a write to CTRL or LOCK_CFG while locked=1.
An error write SHALL modify nothing.
REQ-013 SHALL update INT_FLAG each cycle as flag = (flag & ~clear) | hw_event, where clear is the W1C data; hw_event wins over a simultaneous W1C clear of the same bit.
REQ-014 SHALL update CMD each cycle as (cmd & ~cmd_clr) | set, where set is the W1S data; a write set wins over a simultaneous cmd_clr on the same bit.
REQ-015 SHALL drive irq as a register holding |(INT_FLAG & INT_EN), i.e. one cycle after the flag or enable change.
REQ-016 SHALL pulse wo_pulse high for exactly one cycle after a committed WO write, with wo_data_o holding the written value.
REQ-017 SHALL set locked when a committed CTRL write sets CTRL bit DATA_W-1; locked is sticky until rst and equals CTRL[DATA_W-1].
REQ-018 SHALL return the FSM to IDLE and clear the counter, with no commit, if psel drops mid-transfer.

Reset
REQ-019 SHALL, while rst=1, asynchronously force:
- FSM to IDLE and counter to 0;
- CTRL=CTRL_RST, LOCK_CFG=LOCK_RST;
- INT_FLAG, INT_EN, CMD and WO to 0;
- irq, wo_pulse and locked to 0;
- pready=0, pslverr=0, prdata=0.
REQ-020 SHALL abandon any in-flight transfer on rst assertion; no partial write persists.

Configuration
REQ-021 SHALL, when APB_REGFILE_PSTRB_EN is defined, write only the bytes whose pstrb bit is 1; W1C and W1S operate per enabled byte, and a write with all-zero strobes is a legal no-op.
REQ-022 SHALL, when APB_REGFILE_PSTRB_EN is undefined, omit the pstrb port and write full words.

Structure
REQ-023 SHALL place the FSM state typedef, register index constants and access-type enum in package apb_regfile_v2_pkg.
REQ-024 SHALL implement the FSM and wait counter in sub-module apb_slave_fsm, which outputs pready and a commit strobe.

Verification
REQ-025 WAIT_STATES=3: write CTRL=0x0000_00FF -> pready low for 3 ACCESS cycles, then high for 1; ctrl_o=0xFF on the next cycle.
REQ-026 hw_event bit 4 pulses in the same cycle as a W1C write 0x10 to INT_FLAG -> INT_FLAG[4]=1; then INT_EN=0x10 -> irq=1 one cycle later.
REQ-027 Write CTRL=0x8000_0001, then LOCK_CFG=0 -> locked=1, pslverr=1 on the second write, lock_cfg_o stays 0x12345678 until rst.
REQ-028 Read index 9, read WO, write STATUS -> pslverr=1 and prdata=0 on each.
REQ-029 PSTRB_EN: write CTRL=0xAABBCCDD with pstrb=4'b0101 over CTRL=0 -> ctrl_o=0x00BB00DD.
REQ-030 Assert rst during the ACCESS wait of a CTRL write -> ctrl_o=CTRL_RST, FSM IDLE, wo_pulse=0.
